// File: rtl/truth_sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state encoding,
// legal parameter ranges and the width of the settle-delay counter.
// Imported by truth_table_sweeper and its sub-modules.
package truth_sweep_pkg;

  // Legal parameter ranges of the sweeper
  localparam int N_IN_MIN       = 2;
  localparam int N_IN_MAX       = 8;
  localparam int SETTLE_CYC_MIN = 1;
  localparam int SETTLE_CYC_MAX = 15;

  // Settle counter is sized for the largest legal settle time
  localparam int SETTLE_CNT_W = $clog2(SETTLE_CYC_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_t;

  // A sweep counts as active only while vectors are being driven/checked
  function automatic logic is_busy_state(input sweep_state_t s);
    return (s == ST_SETTLE) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/tally_counter.sv
// Saturation-free up-counter used for the per-sweep tallies.
// Ports: clk, rst (async, active-high), clr (sync clear, wins over en),
//        en (count enable), count (WIDTH-bit tally).
module tally_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of an N_IN-input function in turn, holds each
// for SETTLE_CYC cycles, then compares f_in against latched on/dc masks.
// Ports: clk, rst (async, active-high), start/abort control, on_mask/dc_mask
//        expected function, f_in response; vec_out stimulus, busy/done/pass
//        status, on/off/dc/err tallies. Defining FIRST_ERR_CAPTURE_EN adds
//        first_err_vld/first_err_idx (index of the first mismatch of a sweep).
module truth_table_sweeper
  import truth_sweep_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   on_mask,
  input  logic [2**N_IN-1:0]   dc_mask,
  input  logic                 f_in,
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        on_cnt,
  output logic [N_IN:0]        off_cnt,
  output logic [N_IN:0]        dc_cnt,
  output logic [N_IN:0]        err_cnt
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_idx
`endif
);

  localparam int NVEC = 2**N_IN;
  localparam logic [N_IN-1:0]         LAST_IDX    = {N_IN{1'b1}};
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);

  sweep_state_t            state;
  logic [N_IN-1:0]         idx;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [NVEC-1:0]         on_lat;
  logic [NVEC-1:0]         dc_lat;

  logic accept;
  logic check_go;
  logic cur_on;
  logic cur_dc;
  logic mismatch;

  assign accept   = (state == ST_IDLE) && start && !abort;
  // An aborted CHECK cycle must not touch the tallies
  assign check_go = (state == ST_CHECK) && !abort;
  assign cur_on   = on_lat[idx];
  assign cur_dc   = dc_lat[idx];
  // Don't-care vectors are never compared, even if their on bit is set
  assign mismatch = !cur_dc && (f_in != cur_on);

  assign vec_out = idx;
  assign busy    = is_busy_state(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      on_lat     <= '0;
      dc_lat     <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            on_lat     <= on_mask;
            dc_lat     <= dc_mask;
            idx        <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (idx == LAST_IDX) begin
            state <= ST_DONE;
          end else begin
            idx        <= idx + 1'b1;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // err_cnt already holds the final CHECK's contribution here
          done  <= 1'b1;
          pass  <= (err_cnt == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tally_counter #(.WIDTH(N_IN + 1)) u_on_cnt (
    .clk(clk), .rst(rst), .clr(accept),
    .en(check_go && !cur_dc && cur_on), .count(on_cnt)
  );

  tally_counter #(.WIDTH(N_IN + 1)) u_off_cnt (
    .clk(clk), .rst(rst), .clr(accept),
    .en(check_go && !cur_dc && !cur_on), .count(off_cnt)
  );

  tally_counter #(.WIDTH(N_IN + 1)) u_dc_cnt (
    .clk(clk), .rst(rst), .clr(accept),
    .en(check_go && cur_dc), .count(dc_cnt)
  );

  tally_counter #(.WIDTH(N_IN + 1)) u_err_cnt (
    .clk(clk), .rst(rst), .clr(accept),
    .en(check_go && mismatch), .count(err_cnt)
  );

`ifdef FIRST_ERR_CAPTURE_EN
  // Only the first mismatch of a sweep is kept; later ones are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (accept) begin
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else if (check_go && mismatch && !first_err_vld) begin
      first_err_vld <= 1'b1;
      first_err_idx <= idx;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: random and directed sweeps
// compared against a vector-by-vector reference model of the tallies.
module tb_truth_table_sweeper;

  localparam int N  = 4;
  localparam int S  = 2;
  localparam int NV = 16;
  localparam int LAT = NV * (S + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, abort;
  logic [NV-1:0] on_mask, dc_mask;
  logic [NV-1:0] fun_tab;
  logic          f_in;
  logic [N-1:0]  vec_out;
  logic          busy, done, pass;
  logic [N:0]    on_cnt, off_cnt, dc_cnt, err_cnt;

  logic          start2, abort2;
  logic [3:0]    on_mask2, dc_mask2;
  logic          f_in2;
  logic [1:0]    vec_out2;
  logic          busy2, done2, pass2;
  logic [2:0]    on_cnt2, off_cnt2, dc_cnt2, err_cnt2;

`ifdef FIRST_ERR_CAPTURE_EN
  logic          first_err_vld;
  logic [N-1:0]  first_err_idx;
  logic          first_err_vld2;
  logic [1:0]    first_err_idx2;
`endif

  // Function under test: a lookup table addressed by the driven vector
  assign f_in  = fun_tab[vec_out];
  assign f_in2 = &vec_out2;

  int checks = 0;
  int errors = 0;

  truth_table_sweeper #(.N_IN(N), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .on_mask(on_mask), .dc_mask(dc_mask), .f_in(f_in),
    .vec_out(vec_out), .busy(busy), .done(done), .pass(pass),
    .on_cnt(on_cnt), .off_cnt(off_cnt), .dc_cnt(dc_cnt), .err_cnt(err_cnt)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
`endif
  );

  truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .on_mask(on_mask2), .dc_mask(dc_mask2), .f_in(f_in2),
    .vec_out(vec_out2), .busy(busy2), .done(done2), .pass(pass2),
    .on_cnt(on_cnt2), .off_cnt(off_cnt2), .dc_cnt(dc_cnt2), .err_cnt(err_cnt2)
`ifdef FIRST_ERR_CAPTURE_EN
    , .first_err_vld(first_err_vld2), .first_err_idx(first_err_idx2)
`endif
  );

  // Reference model: classify the first nvec vectors of a sweep
  function automatic void model(input logic [NV-1:0] on, input logic [NV-1:0] dc,
                                input logic [NV-1:0] fn, input int nvec,
                                output int e_on, output int e_off, output int e_dc,
                                output int e_err, output int e_first);
    e_on = 0; e_off = 0; e_dc = 0; e_err = 0; e_first = -1;
    for (int i = 0; i < nvec; i++) begin
      if (dc[i]) begin
        e_dc++;
      end else begin
        if (on[i]) e_on++; else e_off++;
        if (fn[i] != on[i]) begin
          e_err++;
          if (e_first < 0) e_first = i;
        end
      end
    end
  endfunction

  // Start a sweep, scramble the mask inputs after acceptance, wait for done
  task automatic do_sweep(input logic [NV-1:0] on, input logic [NV-1:0] dc, output int lat);
    int c;
    @(negedge clk);
    on_mask = on;
    dc_mask = dc;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    on_mask = NV'($urandom);
    dc_mask = NV'($urandom);
    c = 0;
    lat = -1;
    while (c < 200) begin
      @(posedge clk);
      c++;
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (vec_out !== '0) begin errors++; $display("FAIL reset_vec got %0h want 0", vec_out); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, pass}); end
    checks++; if ({on_cnt, off_cnt, dc_cnt, err_cnt} !== '0) begin errors++; $display("FAIL reset_cnts got %h want 0", {on_cnt, off_cnt, dc_cnt, err_cnt}); end
`ifdef FIRST_ERR_CAPTURE_EN
    checks++; if ({first_err_vld, first_err_idx} !== '0) begin errors++; $display("FAIL reset_first_err got %b/%0d want 0/0", first_err_vld, first_err_idx); end
`endif
  endtask

  task automatic test_directed(input string name, input logic [NV-1:0] fn);
    int lat, e_on, e_off, e_dc, e_err, e_first;
    logic [NV-1:0] on, dc;
    on = 16'h058F;
    dc = 16'h8860;
    fun_tab = fn;
    model(on, dc, fn, NV, e_on, e_off, e_dc, e_err, e_first);
    do_sweep(on, dc, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL %s_latency got %0d want %0d", name, lat, LAT); end
    checks++; if (on_cnt !== 5'(e_on)) begin errors++; $display("FAIL %s_on got %0d want %0d", name, on_cnt, e_on); end
    checks++; if (off_cnt !== 5'(e_off)) begin errors++; $display("FAIL %s_off got %0d want %0d", name, off_cnt, e_off); end
    checks++; if (dc_cnt !== 5'(e_dc)) begin errors++; $display("FAIL %s_dc got %0d want %0d", name, dc_cnt, e_dc); end
    checks++; if (err_cnt !== 5'(e_err)) begin errors++; $display("FAIL %s_err got %0d want %0d", name, err_cnt, e_err); end
    checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL %s_pass got %b want %b", name, pass, e_err == 0); end
`ifdef FIRST_ERR_CAPTURE_EN
    checks++; if (first_err_vld !== (e_first >= 0)) begin errors++; $display("FAIL %s_first_vld got %b want %b", name, first_err_vld, e_first >= 0); end
    if (e_first >= 0) begin
      checks++; if (first_err_idx !== 4'(e_first)) begin errors++; $display("FAIL %s_first_idx got %0d want %0d", name, first_err_idx, e_first); end
    end
`endif
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_random;
    int lat, e_on, e_off, e_dc, e_err, e_first;
    logic [NV-1:0] on, dc;
    for (int it = 0; it < 8; it++) begin
      on = NV'($urandom);
      dc = NV'($urandom & $urandom);
      // Half the runs use a correct function with random don't-care values
      if (it % 2 == 0) fun_tab = (on & ~dc) | (NV'($urandom) & dc);
      else             fun_tab = NV'($urandom);
      model(on, dc, fun_tab, NV, e_on, e_off, e_dc, e_err, e_first);
      do_sweep(on, dc, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", it, lat, LAT); end
      checks++; if ({on_cnt, off_cnt, dc_cnt, err_cnt} !== {5'(e_on), 5'(e_off), 5'(e_dc), 5'(e_err)}) begin
        errors++;
        $display("FAIL rand%0d_counts got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", it,
                 on_cnt, off_cnt, dc_cnt, err_cnt, e_on, e_off, e_dc, e_err);
      end
      checks++; if (pass !== (e_err == 0)) begin errors++; $display("FAIL rand%0d_pass got %b want %b", it, pass, e_err == 0); end
`ifdef FIRST_ERR_CAPTURE_EN
      checks++; if (first_err_vld !== (e_first >= 0) || (e_first >= 0 && first_err_idx !== 4'(e_first))) begin
        errors++;
        $display("FAIL rand%0d_first_err got %b/%0d want %0d", it, first_err_vld, first_err_idx, e_first);
      end
`endif
    end
  endtask

  task automatic test_restart_abort;
    int c, lat, e_on, e_off, e_dc, e_err, e_first, n_done, k_abort;
    logic [NV-1:0] on, dc;
    on = NV'($urandom);
    dc = NV'($urandom & $urandom);
    fun_tab = NV'($urandom);
    model(on, dc, fun_tab, NV, e_on, e_off, e_dc, e_err, e_first);
    // Sweep with a second start pulse at cycle 10
    @(negedge clk);
    on_mask = on; dc_mask = dc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    c = 0; lat = -1;
    while (c < 200) begin
      @(posedge clk);
      c++;
      #1;
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (done) begin lat = c; break; end
    end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL restart_latency got %0d want %0d", lat, LAT); end
    checks++; if (err_cnt !== 5'(e_err)) begin errors++; $display("FAIL restart_err got %0d want %0d", err_cnt, e_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %b want 0", busy); end

    // Abort at cycle 20: only CHECKs that finished before it are tallied
    k_abort = 20;
    @(negedge clk);
    on_mask = on; dc_mask = dc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (k_abort) @(posedge clk);
    #1;
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    model(on, dc, fun_tab, k_abort / (S + 1), e_on, e_off, e_dc, e_err, e_first);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", n_done); end
    checks++; if ({on_cnt, off_cnt, dc_cnt, err_cnt} !== {5'(e_on), 5'(e_off), 5'(e_dc), 5'(e_err)}) begin
      errors++;
      $display("FAIL abort_counts got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               on_cnt, off_cnt, dc_cnt, err_cnt, e_on, e_off, e_dc, e_err);
    end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL abort_pass got %b want 0", pass); end
  endtask

  task automatic test_reset_mid;
    int lat, e_on, e_off, e_dc, e_err, e_first;
    logic [NV-1:0] on, dc;
    on = NV'($urandom);
    dc = NV'($urandom & $urandom);
    fun_tab = NV'($urandom);
    @(negedge clk);
    on_mask = on; dc_mask = dc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({vec_out, busy, done, pass} !== '0) begin errors++; $display("FAIL midrst_outputs got %h want 0", {vec_out, busy, done, pass}); end
    checks++; if ({on_cnt, off_cnt, dc_cnt, err_cnt} !== '0) begin errors++; $display("FAIL midrst_cnts got %h want 0", {on_cnt, off_cnt, dc_cnt, err_cnt}); end
    @(negedge clk);
    rst = 1'b0;
    model(on, dc, fun_tab, NV, e_on, e_off, e_dc, e_err, e_first);
    do_sweep(on, dc, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL postrst_latency got %0d want %0d", lat, LAT); end
    checks++; if ({on_cnt, off_cnt, dc_cnt, err_cnt} !== {5'(e_on), 5'(e_off), 5'(e_dc), 5'(e_err)}) begin
      errors++;
      $display("FAIL postrst_counts got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               on_cnt, off_cnt, dc_cnt, err_cnt, e_on, e_off, e_dc, e_err);
    end
  endtask

  task automatic test_small;
    int c, lat;
    @(negedge clk);
    on_mask2 = 4'b1000; dc_mask2 = 4'b0000; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    c = 0; lat = -1;
    while (c < 100) begin
      @(posedge clk);
      c++;
      #1;
      if (done2) begin lat = c; break; end
    end
    checks++; if (lat !== 9) begin errors++; $display("FAIL small_latency got %0d want 9", lat); end
    checks++; if ({on_cnt2, off_cnt2, dc_cnt2, err_cnt2} !== {3'd1, 3'd3, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL small_counts got %0d/%0d/%0d/%0d want 1/3/0/0", on_cnt2, off_cnt2, dc_cnt2, err_cnt2);
    end
    checks++; if (pass2 !== 1'b1) begin errors++; $display("FAIL small_pass got %b want 1", pass2); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; abort = 1'b0;
    on_mask = '0; dc_mask = '0; fun_tab = '0;
    start2 = 1'b0; abort2 = 1'b0; on_mask2 = '0; dc_mask2 = '0;
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset;
    test_directed("correct", 16'h058F);
    test_directed("stuck1", 16'hFFFF);
    test_directed("stuck0", 16'h0000);
    test_random;
    test_restart_abort;
    test_reset_mid;
    test_small;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of function inputs (range 2..8).
REQ-002 SHALL have parameter SETTLE_CYC, default 2: cycles each input vector is held before sampling (range 1..15).
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a full sweep.
REQ-006 SHALL have port abort, input, 1: synchronous sweep cancel.
REQ-007 SHALL have port on_mask, input, 2^N_IN: bit i=1 means f must be 1 at vector i.
REQ-008 SHALL have port dc_mask, input, 2^N_IN: bit i=1 means vector i is don't-care.
REQ-009 SHALL have port f_in, input, 1: function-under-test output.
REQ-010 SHALL have port vec_out, output, N_IN: vector driven to the function under test, MSB = first input.
REQ-011 SHALL have ports busy, done, pass, output, 1 each: busy = sweep active; done = one-cycle completion pulse; pass = last sweep had zero errors.
REQ-012 SHALL have ports on_cnt, off_cnt, dc_cnt, err_cnt, output, N_IN+1 each: per-sweep tallies.

Function
REQ-013 SHALL implement FSM IDLE, SETTLE, CHECK, DONE; vec_out SHALL equal the index register in all states.
REQ-014 In IDLE, start=1 and abort=0 SHALL latch on_mask/dc_mask, clear all counts, clear pass, set index to 0 and enter SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to CHECK.
REQ-016 CHECK SHALL last one cycle and classify vector i: dc bit set -> dc_cnt+1, no compare; else on bit set -> on_cnt+1, else off_cnt+1; mismatch between f_in and the on bit -> err_cnt+1.
REQ-017 When both on and dc bits are set, dc SHALL take precedence.
REQ-018 CHECK at index 2^N_IN-1 SHALL go to DONE; otherwise index+1 and go to SETTLE.
REQ-019 DONE SHALL last one cycle with done=1, set pass=(err_cnt==0), then return to IDLE.
REQ-020 Start-accept edge to done high SHALL be 2^N_IN*(SETTLE_CYC+1)+1 cycles (49 for defaults).
REQ-021 busy SHALL be 1 in SETTLE and CHECK only.
REQ-022 start SHALL be ignored outside IDLE; mask changes after latching SHALL have no effect.
REQ-023 abort=1 in SETTLE or CHECK SHALL go to IDLE next cycle with counts frozen, no done pulse, pass=0; abort SHALL win over simultaneous start.
REQ-024 Counters SHALL not overflow (N_IN+1 bits holds 2^N_IN).

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, index 0, vec_out 0, busy/done/pass 0, all counts 0, including mid-sweep.

Configuration
REQ-026 With FIRST_ERR_CAPTURE_EN defined, the module SHALL add outputs first_err_vld (1) and first_err_idx (N_IN), which hold the index of the first mismatch of the current sweep, are cleared on start-accept and reset, and are never overwritten within a sweep.
REQ-027 Without FIRST_ERR_CAPTURE_EN, those ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package truth_sweep_pkg SHALL hold the FSM state encoding and the range-limit localparams for N_IN/SETTLE_CYC.
REQ-029 Each tally SHALL be an instance of sub-module tally_counter (sync clear, enable, async reset, parameter width).

Verification
REQ-030 on_mask=16'h058F, dc_mask=16'h8860, f_in from the correct function -> on=7, off=5, dc=4, err=0, pass=1, done 49 cycles after start.
REQ-031 Same masks, f_in stuck 1 -> err=5, pass=0, first_err_idx=4.
REQ-032 Same masks, f_in stuck 0 -> err=7, pass=0, first_err_idx=0.
REQ-033 start pulsed again at cycle 10 of a sweep -> ignored, done still at 49; abort at cycle 20 -> IDLE next cycle, no done pulse, counts frozen.
REQ-034 rst asserted mid-sweep between clock edges -> all outputs 0 immediately; new start gives a clean full sweep.
REQ-035 N_IN=2, SETTLE_CYC=1, on_mask=4'b1000, dc_mask=0, f_in=AND of vec_out bits -> err=0, done 9 cycles after start.
